v_ctx_sched: RTL and testbench

//  Per-context command scheduler for the list-update datapath.
//  - Accepts (context id, cmd, key, volume) commands.
//  - Fetches the context's v_pkg::state_t from the state table and issues it

---
 rtl/v_ctx_sched.sv | 191 +++++++++++++++++++
 tb/tb_v_ctx_sched.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/v_ctx_sched.sv
// ---------------------------------------------------------------------------
// v_ctx_sched
// Per-context command scheduler for the list-update datapath.
// Accepts (context id, op, key, volume) commands, fetches the context state
// from an external state table, issues command + state to the update datapath
// and writes the returned state back. A per-context scoreboard holds off a
// second command to a context until the first one's state is written back.
// After reset the whole state table is swept to zero before commands are
// taken.
//
// Ports
//   clk, arst              clock, asynchronous active-high reset
//   cmd_vld / cmd_rdy      command handshake
//   cmd_id/op/key/volume   command fields
//   st_rd_en/addr/data     state table read port (data one cycle after en)
//   st_wr_en/addr/data     state table write port
//   dp_vld, dp_op/key/volume/state   datapath issue (no backpressure)
//   dp_rsp_vld/state       datapath result, returned in issue order
//   init_done              table clear sweep complete (sticky until reset)
// ---------------------------------------------------------------------------
module v_ctx_sched #(
    parameter int CONTEXT_N    = 8,
    parameter int MAX_INFLIGHT = 4,
    parameter int KEY_BITS     = 8,
    parameter int VOLUME_BITS  = 8,
    parameter int STATE_BITS   = 16,
    localparam int ID_W        = (CONTEXT_N > 1) ? $clog2(CONTEXT_N) : 1
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic                   cmd_vld,
    output logic                   cmd_rdy,
    input  logic [ID_W-1:0]        cmd_id,
    input  logic [1:0]             cmd_op,
    input  logic [KEY_BITS-1:0]    cmd_key,
    input  logic [VOLUME_BITS-1:0] cmd_volume,
    output logic                   st_rd_en,
    output logic [ID_W-1:0]        st_rd_addr,
    input  logic [STATE_BITS-1:0]  st_rd_data,
    output logic                   st_wr_en,
    output logic [ID_W-1:0]        st_wr_addr,
    output logic [STATE_BITS-1:0]  st_wr_data,
    output logic                   dp_vld,
    output logic [1:0]             dp_op,
    output logic [KEY_BITS-1:0]    dp_key,
    output logic [VOLUME_BITS-1:0] dp_volume,
    output logic [STATE_BITS-1:0]  dp_state,
    input  logic                   dp_rsp_vld,
    input  logic [STATE_BITS-1:0]  dp_rsp_state,
    output logic                   init_done
);

    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
    localparam int PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;

    typedef enum logic {S_INIT, S_RUN} state_e;

    state_e                 state_q, state_d;
    logic [ID_W-1:0]        initAddr_q, initAddr_d;
    logic [CONTEXT_N-1:0]   scoreboard_q, scoreboard_d;
    logic [CNT_W-1:0]       inflight_q, inflight_d;
    logic [ID_W-1:0]        idFifo_q [MAX_INFLIGHT];
    logic [PTR_W-1:0]       wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic                   dpVld_q;
    logic [1:0]             dpOp_q;
    logic [KEY_BITS-1:0]    dpKey_q;
    logic [VOLUME_BITS-1:0] dpVolume_q;

    logic                   running, idOk, accept, writeback;
    logic [31:0]            idExt;
    logic [ID_W-1:0]        headId;
    logic                   stWrEn;

    function automatic logic [PTR_W-1:0] ptrNext(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_INFLIGHT - 1)) ? '0 : p + 1'b1;
    endfunction

    // The inflight count doubles as the id FIFO occupancy: both change on
    // accept and writeback only. Ids outside the table are never accepted.
    assign running   = (state_q == S_RUN);
    assign idExt     = 32'(cmd_id);
    assign idOk      = (idExt < 32'(CONTEXT_N));
    assign headId    = idFifo_q[rdPtr_q];
    assign cmd_rdy   = running & idOk & ~scoreboard_q[cmd_id]
                     & (inflight_q < CNT_W'(MAX_INFLIGHT));
    assign accept    = cmd_vld & cmd_rdy;
    assign writeback = running & dp_rsp_vld & (inflight_q != '0);

    assign st_rd_en   = accept;
    assign st_rd_addr = accept ? cmd_id : '0;

    assign dp_vld    = dpVld_q;
    assign dp_op     = dpOp_q;
    assign dp_key    = dpKey_q;
    assign dp_volume = dpVolume_q;
    assign dp_state  = dpVld_q ? st_rd_data : '0;
    assign init_done = running;

    // The FSM resets into the clear sweep, so the raw write strobe would be
    // high while reset is held; gating it keeps every output quiet in reset.
    assign st_wr_en = stWrEn & ~arst;

    // Sweep FSM and the write port: INIT writes zero to every row in
    // ascending order, RUN forwards datapath results to the FIFO head's row.
    always_comb begin
        state_d    = state_q;
        initAddr_d = initAddr_q;
        stWrEn     = 1'b0;
        st_wr_addr = '0;
        st_wr_data = '0;
        unique case (state_q)
            S_INIT: begin
                stWrEn     = 1'b1;
                st_wr_addr = initAddr_q;
                if (initAddr_q == ID_W'(CONTEXT_N - 1)) begin
                    state_d = S_RUN;
                end else begin
                    initAddr_d = initAddr_q + 1'b1;
                end
            end
            S_RUN: begin
                if (writeback) begin
                    stWrEn     = 1'b1;
                    st_wr_addr = headId;
                    st_wr_data = dp_rsp_state;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    // Scoreboard, occupancy and FIFO pointers. A writeback and an accept can
    // never target the same id in one cycle because the busy bit blocks it.
    always_comb begin
        scoreboard_d = scoreboard_q;
        inflight_d   = inflight_q;
        wrPtr_d      = wrPtr_q;
        rdPtr_d      = rdPtr_q;
        if (writeback) begin
            scoreboard_d[headId] = 1'b0;
            rdPtr_d              = ptrNext(rdPtr_q);
        end
        if (accept) begin
            scoreboard_d[cmd_id] = 1'b1;
            wrPtr_d              = ptrNext(wrPtr_q);
        end
        unique case ({accept, writeback})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    // State registers; a reset drops all in-flight work and restarts the sweep.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q      <= S_INIT;
            initAddr_q   <= '0;
            scoreboard_q <= '0;
            inflight_q   <= '0;
            wrPtr_q      <= '0;
            rdPtr_q      <= '0;
            for (int i = 0; i < MAX_INFLIGHT; i++) begin
                idFifo_q[i] <= '0;
            end
            dpVld_q      <= 1'b0;
            dpOp_q       <= '0;
            dpKey_q      <= '0;
            dpVolume_q   <= '0;
        end else begin
            state_q      <= state_d;
            initAddr_q   <= initAddr_d;
            scoreboard_q <= scoreboard_d;
            inflight_q   <= inflight_d;
            wrPtr_q      <= wrPtr_d;
            rdPtr_q      <= rdPtr_d;
            dpVld_q      <= accept;
            if (accept) begin
                idFifo_q[wrPtr_q] <= cmd_id;
                dpOp_q            <= cmd_op;
                dpKey_q           <= cmd_key;
                dpVolume_q        <= cmd_volume;
            end
        end
    end

    // A datapath result with nothing outstanding has no row to go to.
    rspNeedsEntry: assert property (@(posedge clk) disable iff (arst)
        dp_rsp_vld |-> (inflight_q != '0));

endmodule

// File: tb/tb_v_ctx_sched.sv
// ---------------------------------------------------------------------------
// tb_v_ctx_sched
// Testbench for v_ctx_sched. The bench plays the state table (a plain array)
// and the update datapath (arithmetic on state/key/volume, responses in issue
// order). A reference model built from queues tracks outstanding contexts,
// the expected table contents and the expected issue stream.
// ---------------------------------------------------------------------------
module tb_v_ctx_sched;

    localparam int CN = 8;
    localparam int MI = 4;
    localparam int KB = 8;
    localparam int VB = 8;
    localparam int SB = 16;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          arst;
    logic          cmdVld, cmdRdy;
    logic [IW-1:0] cmdId;
    logic [1:0]    cmdOp;
    logic [KB-1:0] cmdKey;
    logic [VB-1:0] cmdVolume;
    logic          stRdEn, stWrEn;
    logic [IW-1:0] stRdAddr, stWrAddr;
    logic [SB-1:0] stRdData, stWrData;
    logic          dpVld;
    logic [1:0]    dpOp;
    logic [KB-1:0] dpKey;
    logic [VB-1:0] dpVolume;
    logic [SB-1:0] dpState;
    logic          rspVld;
    logic [SB-1:0] rspState;
    logic          initDone;

    typedef struct {
        logic [IW-1:0] id;
        logic [1:0]    op;
        logic [KB-1:0] key;
        logic [VB-1:0] vol;
        logic [SB-1:0] st;
        int            t;
    } rec_t;

    logic [SB-1:0] mem [CN];
    logic [SB-1:0] tableModel [CN];
    logic [IW-1:0] pendQ [$];
    rec_t          expIssue [$];
    rec_t          issuedQ [$];
    int            checks = 0;
    int            errors = 0;
    int            cycleNum = 0;
    int            rspLatency = 1;
    bit            dpHold = 1'b0;
    bit            randRsp = 1'b0;
    bit            prevAccept = 1'b0;
    bit            lastAccept = 1'b0;
    bit            lastWb = 1'b0;
    logic [SB-1:0] lastIssueState = '0;

    always #5 clk = ~clk;

    v_ctx_sched #(
        .CONTEXT_N(CN), .MAX_INFLIGHT(MI), .KEY_BITS(KB),
        .VOLUME_BITS(VB), .STATE_BITS(SB)
    ) dut (
        .clk(clk), .arst(arst),
        .cmd_vld(cmdVld), .cmd_rdy(cmdRdy), .cmd_id(cmdId), .cmd_op(cmdOp),
        .cmd_key(cmdKey), .cmd_volume(cmdVolume),
        .st_rd_en(stRdEn), .st_rd_addr(stRdAddr), .st_rd_data(stRdData),
        .st_wr_en(stWrEn), .st_wr_addr(stWrAddr), .st_wr_data(stWrData),
        .dp_vld(dpVld), .dp_op(dpOp), .dp_key(dpKey), .dp_volume(dpVolume),
        .dp_state(dpState), .dp_rsp_vld(rspVld), .dp_rsp_state(rspState),
        .init_done(initDone)
    );

    // State table: registered read, write visible to reads from the next cycle.
    always @(posedge clk) begin
        if (stRdEn) stRdData <= mem[stRdAddr];
        if (stWrEn) mem[stWrAddr] <= stWrData;
    end

    // Time limit so a stuck design still ends the run.
    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    // What the datapath does to a context's state.
    function automatic logic [SB-1:0] dpModel(input logic [SB-1:0] st, input logic [1:0] op,
                                              input logic [KB-1:0] key, input logic [VB-1:0] vol);
        logic [SB-1:0] kv;
        kv = {key, vol};
        case (op)
            2'd0:    return st + kv;
            2'd1:    return st - kv;
            2'd2:    return st ^ kv;
            default: return st;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock in RUN: datapath responder, model-based checks of every
    // output, then model update for whatever the clock edge commits.
    task automatic applyStimulus();
        rec_t r;
        bit   expRdy;
        rspVld   = 1'b0;
        rspState = '0;
        if (!dpHold && issuedQ.size() > 0 && (cycleNum - issuedQ[0].t) >= rspLatency
            && (!randRsp || $urandom_range(0, 2) != 0)) begin
            rspVld   = 1'b1;
            rspState = dpModel(issuedQ[0].st, issuedQ[0].op, issuedQ[0].key, issuedQ[0].vol);
        end
        #1;
        expRdy = (pendQ.size() < MI);
        foreach (pendQ[i]) if (pendQ[i] == cmdId) expRdy = 1'b0;
        checkOutput("cmd_rdy", 32'(cmdRdy), 32'(expRdy));
        lastAccept = cmdVld && cmdRdy;
        checkOutput("st_rd_en", 32'(stRdEn), 32'(lastAccept));
        if (lastAccept) checkOutput("st_rd_addr", 32'(stRdAddr), 32'(cmdId));
        checkOutput("dp_vld", 32'(dpVld), 32'(prevAccept));
        if (dpVld && expIssue.size() > 0) begin
            r = expIssue.pop_front();
            checkOutput("dp_op", 32'(dpOp), 32'(r.op));
            checkOutput("dp_key", 32'(dpKey), 32'(r.key));
            checkOutput("dp_volume", 32'(dpVolume), 32'(r.vol));
            checkOutput("dp_state", 32'(dpState), 32'(r.st));
            lastIssueState = dpState;
            r.t = cycleNum;
            issuedQ.push_back(r);
        end
        checkOutput("st_wr_en", 32'(stWrEn), 32'(rspVld));
        lastWb = rspVld;
        if (rspVld) begin
            checkOutput("st_wr_addr", 32'(stWrAddr), 32'(pendQ[0]));
            checkOutput("st_wr_data", 32'(stWrData), 32'(rspState));
            tableModel[pendQ[0]] = rspState;
            void'(pendQ.pop_front());
            issuedQ.delete(0);
        end
        if (lastAccept) begin
            r.id  = cmdId;
            r.op  = cmdOp;
            r.key = cmdKey;
            r.vol = cmdVolume;
            r.st  = tableModel[cmdId];
            r.t   = cycleNum;
            expIssue.push_back(r);
            pendQ.push_back(cmdId);
        end
        prevAccept = lastAccept;
        @(negedge clk);
        cycleNum++;
    endtask

    task automatic sendCmd(input int id, input int op, input int key, input int vol, output int waited);
        cmdVld    = 1'b1;
        cmdId     = IW'(id);
        cmdOp     = 2'(op);
        cmdKey    = KB'(key);
        cmdVolume = VB'(vol);
        waited    = 0;
        applyStimulus();
        while (!lastAccept && waited < 60) begin
            waited++;
            applyStimulus();
        end
        if (!lastAccept) checkOutput("send_timeout", 32'(lastAccept), 32'd1);
        cmdVld = 1'b0;
    endtask

    task automatic drainPipe();
        int n = 0;
        cmdVld = 1'b0;
        dpHold = 1'b0;
        while ((pendQ.size() > 0 || prevAccept) && n < 100) begin
            applyStimulus();
            n++;
        end
        checkOutput("drain_empty", 32'(pendQ.size()), 32'd0);
    endtask

    // Assert reset (from wherever the design is), check quiet outputs and
    // cleared internals, then follow the clear sweep row by row.
    task automatic resetAndInit();
        arst     = 1'b1;
        cmdVld   = 1'b0;
        cmdId    = '0;
        rspVld   = 1'b0;
        rspState = '0;
        dpHold   = 1'b0;
        pendQ.delete();
        expIssue.delete();
        issuedQ.delete();
        prevAccept = 1'b0;
        for (int i = 0; i < CN; i++) tableModel[i] = '0;
        #1;
        checkOutput("rst_cmd_rdy", 32'(cmdRdy), 32'd0);
        checkOutput("rst_st_wr_en", 32'(stWrEn), 32'd0);
        checkOutput("rst_st_rd_en", 32'(stRdEn), 32'd0);
        checkOutput("rst_dp_vld", 32'(dpVld), 32'd0);
        checkOutput("rst_init_done", 32'(initDone), 32'd0);
        checkOutput("rst_scoreboard", 32'(dut.scoreboard_q), 32'd0);
        checkOutput("rst_inflight", 32'(dut.inflight_q), 32'd0);
        @(negedge clk);
        arst = 1'b0;
        for (int i = 0; i < CN; i++) begin
            #1;
            checkOutput("init_wr_en", 32'(stWrEn), 32'd1);
            checkOutput("init_wr_addr", 32'(stWrAddr), 32'(i));
            checkOutput("init_wr_data", 32'(stWrData), 32'd0);
            checkOutput("init_cmd_rdy", 32'(cmdRdy), 32'd0);
            checkOutput("init_done_low", 32'(initDone), 32'd0);
            @(negedge clk);
        end
        #1;
        checkOutput("init_done_high", 32'(initDone), 32'd1);
        checkOutput("init_wr_idle", 32'(stWrEn), 32'd0);
        for (int i = 0; i < CN; i++) checkOutput("init_row_zero", 32'(mem[i]), 32'd0);
    endtask

    initial begin
        int w;
        int waitCnt;
        arst      = 1'b0;
        cmdVld    = 1'b0;
        cmdId     = '0;
        cmdOp     = '0;
        cmdKey    = '0;
        cmdVolume = '0;
        rspVld    = 1'b0;
        rspState  = '0;
        #2;

        $display("[TB] reset and table clear sweep");
        resetAndInit();

        $display("[TB] single ADD to context 1");
        rspLatency = 2;
        sendCmd(1, 0, 8'h10, 8'h05, w);
        checkOutput("single_wait", 32'(w), 32'd0);
        drainPipe();
        checkOutput("single_row1", 32'(mem[1]), 32'h1005);

        $display("[TB] back-to-back ADD/DELETE on context 2");
        rspLatency = 3;
        sendCmd(2, 0, 8'h22, 8'h33, w);
        sendCmd(2, 1, 8'h01, 8'h02, w);
        checkOutput("raw_wait", 32'(w), 32'd4);
        applyStimulus();
        checkOutput("raw_read_new", 32'(lastIssueState), 32'h2233);
        drainPipe();
        checkOutput("raw_row2", 32'(mem[2]), 32'h2131);

        $display("[TB] inflight limit with a stalled datapath");
        rspLatency = 1;
        dpHold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sendCmd(i, 2, 8'h40 + i, 8'h11, w);
            checkOutput("full_fill_wait", 32'(w), 32'd0);
        end
        cmdVld = 1'b1; cmdId = 3'd4; cmdOp = 2'd0; cmdKey = 8'h04; cmdVolume = 8'h44;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("full_blocked", 32'(lastAccept), 32'd0);
        end
        dpHold = 1'b0;
        applyStimulus();
        checkOutput("full_wb_seen", 32'(lastWb), 32'd1);
        checkOutput("full_wb_blocked", 32'(lastAccept), 32'd0);
        applyStimulus();
        checkOutput("full_then_accept", 32'(lastAccept), 32'd1);
        cmdVld = 1'b0;
        drainPipe();

        $display("[TB] accept and writeback in the same cycle at inflight 3");
        dpHold = 1'b1;
        for (int i = 0; i < 3; i++) sendCmd(i, 0, 8'h01, 8'h01, w);
        applyStimulus();
        checkOutput("three_inflight", 32'(dut.inflight_q), 32'd3);
        cmdVld = 1'b1; cmdId = 3'd3; cmdOp = 2'd0; cmdKey = 8'h30; cmdVolume = 8'h03;
        dpHold = 1'b0;
        applyStimulus();
        checkOutput("same_cycle_accept", 32'(lastAccept), 32'd1);
        checkOutput("same_cycle_wb", 32'(lastWb), 32'd1);
        checkOutput("same_cycle_count", 32'(dut.inflight_q), 32'd3);
        cmdVld = 1'b0;
        drainPipe();

        $display("[TB] randomized traffic");
        randRsp = 1'b1;
        waitCnt = 0;
        for (int k = 0; k < 300; k++) begin
            if (!cmdVld && $urandom_range(0, 3) != 0) begin
                cmdVld    = 1'b1;
                cmdId     = IW'($urandom_range(0, ($urandom_range(0, 1) != 0) ? 3 : 7));
                cmdOp     = 2'($urandom_range(0, 3));
                cmdKey    = KB'($urandom);
                cmdVolume = VB'($urandom);
                waitCnt   = 0;
            end
            applyStimulus();
            if (lastAccept) cmdVld = 1'b0;
            else if (cmdVld) waitCnt++;
            if (waitCnt > 60) begin
                checkOutput("rand_stall", 32'(lastAccept), 32'd1);
                cmdVld  = 1'b0;
                waitCnt = 0;
            end
        end
        randRsp = 1'b0;
        drainPipe();
        for (int i = 0; i < CN; i++) checkOutput("rand_table_row", 32'(mem[i]), 32'(tableModel[i]));

        $display("[TB] reset with two commands in flight");
        dpHold = 1'b1;
        sendCmd(5, 0, 8'h55, 8'h55, w);
        sendCmd(6, 0, 8'h66, 8'h66, w);
        applyStimulus();
        resetAndInit();
        for (int i = 0; i < 4; i++) applyStimulus();
        checkOutput("post_rst_row5", 32'(mem[5]), 32'd0);
        checkOutput("post_rst_row6", 32'(mem[6]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
